// File: rtl/caesar_msg_ctrl.sv
// Message-level sequencer for the two-key Caesar cipher core.
// Accepts one command per message, validates keys, streams characters through
// the core (one in flight per cycle) and returns results via a small FIFO.
// Optional build macro: CAESAR_CTRL_ABORT_EN adds the abort input and the
// sts_aborted status output.
module caesar_msg_ctrl #(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned OBUF_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CAESAR_CTRL_ABORT_EN
  input  logic             abort,
  output logic             sts_aborted,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mode,
  input  logic             cmd_dir,
  input  logic [4:0]       cmd_key1,
  input  logic [4:0]       cmd_key2,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_last,
  output logic             core_ptxt_valid,
  output logic             core_mode,
  output logic             core_key_shift_dir,
  output logic [4:0]       core_key_shift_num_1,
  output logic [4:0]       core_key_shift_num_2,
  output logic [7:0]       core_ptxt_char,
  input  logic [7:0]       core_ctxt_char,
  input  logic             core_err_invalid_ptxt_char,
  output logic             done,
  output logic             sts_err_key,
  output logic [LEN_W-1:0] sts_bad_cnt,
  output logic [LEN_W-1:0] sts_char_cnt
);

  localparam int unsigned PtrW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state;
  logic             r_mode;
  logic             r_dir;
  logic [4:0]       r_key1;
  logic [4:0]       r_key2;
  logic [LEN_W-1:0] r_rem;
  logic             r_inflight;
  logic             r_inflight_last;
  logic [7:0]       r_saved_char;
  logic             r_err_key;
  logic [LEN_W-1:0] r_bad_cnt;
  logic [LEN_W-1:0] r_char_cnt;
  logic [7:0]       r_buf_char [OBUF_DEPTH];
  logic             r_buf_last [OBUF_DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_cnt;

  logic w_abort;
  logic w_room;
  logic w_issue;
  logic w_push;
  logic w_pop;
  logic w_keys_bad;
  logic [7:0] w_push_char;

`ifdef CAESAR_CTRL_ABORT_EN
  logic r_aborted;
  assign w_abort     = abort && ((r_state == StRun) || (r_state == StDrain));
  assign sts_aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // Issue only when every char already owed to the buffer still has a slot.
  assign w_room     = (32'(r_cnt) + 32'(r_inflight)) < OBUF_DEPTH;
  assign in_ready   = (r_state == StRun) && (r_rem != '0) && w_room && !w_abort;
  assign w_issue    = in_valid && in_ready;
  assign w_push     = r_inflight;
  assign w_pop      = out_valid && out_ready;
  assign w_keys_bad = (cmd_key1 > 5'd26) || (cmd_key2 > 5'd26) || (cmd_key1 == cmd_key2);
  // Non-letters come back flagged from the core; pass the original through.
  assign w_push_char = core_err_invalid_ptxt_char ? r_saved_char : core_ctxt_char;

  assign cmd_ready            = (r_state == StIdle);
  assign done                 = (r_state == StDone);
  assign out_valid            = (r_cnt != '0);
  assign out_char             = out_valid ? r_buf_char[r_rptr] : 8'h00;
  assign out_last             = out_valid && r_buf_last[r_rptr];
  assign core_ptxt_valid      = w_issue;
  assign core_ptxt_char       = w_issue ? in_char : 8'h00;
  assign core_mode            = r_mode;
  assign core_key_shift_dir   = r_dir;
  assign core_key_shift_num_1 = r_key1;
  assign core_key_shift_num_2 = r_key2;
  assign sts_err_key          = r_err_key;
  assign sts_bad_cnt          = r_bad_cnt;
  assign sts_char_cnt         = r_char_cnt;

  // Sequencer FSM, in-flight tracking, output FIFO and status counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_mode          <= 1'b0;
      r_dir           <= 1'b0;
      r_key1          <= '0;
      r_key2          <= '0;
      r_rem           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_saved_char    <= '0;
      r_err_key       <= 1'b0;
      r_bad_cnt       <= '0;
      r_char_cnt      <= '0;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_cnt           <= '0;
      for (int i = 0; i < int'(OBUF_DEPTH); i++) begin
        r_buf_char[i] <= '0;
        r_buf_last[i] <= 1'b0;
      end
`ifdef CAESAR_CTRL_ABORT_EN
      r_aborted       <= 1'b0;
`endif
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_rem == LEN_W'(1));
      if (w_issue) r_saved_char <= in_char;

      if (w_push) begin
        r_buf_char[r_wptr] <= w_push_char;
        r_buf_last[r_wptr] <= r_inflight_last;
        r_wptr <= (r_wptr == PtrW'(OBUF_DEPTH - 1)) ? '0 : r_wptr + PtrW'(1);
        if (core_err_invalid_ptxt_char) r_bad_cnt <= r_bad_cnt + LEN_W'(1);
      end
      if (w_pop) begin
        r_rptr     <= (r_rptr == PtrW'(OBUF_DEPTH - 1)) ? '0 : r_rptr + PtrW'(1);
        r_char_cnt <= r_char_cnt + LEN_W'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CntW'(1);
      end

      unique case (r_state)
        StIdle: begin
          if (cmd_valid) begin
            r_mode     <= cmd_mode;
            r_dir      <= cmd_dir;
            r_key1     <= cmd_key1;
            r_key2     <= cmd_key2;
            r_rem      <= cmd_len;
            r_bad_cnt  <= '0;
            r_char_cnt <= '0;
            r_err_key  <= w_keys_bad;
`ifdef CAESAR_CTRL_ABORT_EN
            r_aborted  <= 1'b0;
`endif
            if (w_keys_bad || (cmd_len == '0)) r_state <= StDone;
            else                               r_state <= StRun;
          end
        end
        StRun: begin
          if (w_issue) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (!r_inflight && (r_cnt == '0)) r_state <= StDone;
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase

      // Abort wins over everything above: flush and finish the message.
      if (w_abort) begin
        r_cnt      <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_inflight <= 1'b0;
        r_state    <= StDone;
`ifdef CAESAR_CTRL_ABORT_EN
        r_aborted  <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/caesar_msg_ctrl.md
Name: caesar_msg_ctrl

Overview:
Message-level sequencer for the two-key Caesar cipher core. It accepts one command per message (mode, direction, two shift keys, length) and validates the keys before any character is issued. It then streams characters from an input valid/ready channel into the core, one in flight per cycle, merges core results with passthrough of non-letters, and returns them on an output valid/ready channel through a small output buffer. It sits between the host/byte interface and a single core instance.

Parameters:
LEN_W, 8, width of message length and status counters (max message = 2^LEN_W-1 chars)
OBUF_DEPTH, 3, output buffer entries (>=2); 3 sustains 1 char/cycle

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  controller idle, command accepted when both high
cmd_mode  in  1  0=encrypt, 1=decrypt
cmd_dir  in  1  0=right shift, 1=left shift
cmd_key1  in  5  first shift key
cmd_key2  in  5  second shift key
cmd_len  in  LEN_W  characters in message
in_valid  in  1  input char offered
in_ready  out  1  input char accepted
in_char  in  8  input char
out_valid  out  1  result char available
out_ready  in  1  sink accepts result
out_char  out  8  result char
out_last  out  1  final char of message
core_ptxt_valid  out  1  to core ptxt_valid
core_mode  out  1  to core mode
core_key_shift_dir  out  1  to core key_shift_dir
core_key_shift_num_1  out  5  to core key 1
core_key_shift_num_2  out  5  to core key 2
core_ptxt_char  out  8  to core ptxt_char
core_ctxt_char  in  8  from core ctxt_char
core_err_invalid_ptxt_char  in  1  from core
done  out  1  one-cycle pulse at message end
sts_err_key  out  1  last command rejected for bad keys
sts_bad_cnt  out  LEN_W  non-letters passed through in current/last message
sts_char_cnt  out  LEN_W  chars emitted in current/last message

Behaviour:
- Reset (rst_n low at posedge clk): state IDLE; all outputs 0 except cmd_ready=1; buffer, in-flight flag, counters and latched config cleared. Any in-flight char is dropped. The core shares rst_n.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: cmd_ready=1, in_ready=0, core_ptxt_valid=0. On accept, latch mode, dir, key1, key2 and rem=cmd_len, and clear sts_bad_cnt and sts_char_cnt.
  - Key check: invalid if key1>26, key2>26, or key1==key2. If invalid, set sts_err_key=1 and go to DONE with no chars consumed.
  - If keys are valid and cmd_len==0: clear sts_err_key and go to DONE.
  - Otherwise: clear sts_err_key and go to RUN.
- Core config outputs are driven from latched registers and stay stable from accept until the next accept.
- RUN issue rule: in_ready = (rem!=0) && (obuf_cnt + inflight < OBUF_DEPTH). Both terms are registered values and do not depend on the same-cycle out_ready.
  - On in_valid && in_ready: core_ptxt_valid=1, core_ptxt_char=in_char (combinational pass-through); save in_char in a delay register; set inflight=1; rem-=1.
  - With no issue in a cycle, inflight is cleared.
  - When the issue makes rem 0, go to DRAIN.
- Result capture: one cycle after an issue, the core output is valid.
  - If core_err_invalid_ptxt_char=1, push the saved original char and increment sts_bad_cnt.
  - Otherwise, push core_ctxt_char.
  - The pushed entry carries last=1 if it was the message's final char.
  - Core error/ready outputs are ignored in cycles with no issue one cycle earlier.
- Output buffer: FIFO. out_valid=!empty. Pop on out_valid && out_ready, which increments sts_char_cnt. Push and pop in the same cycle leave the count unchanged. Overflow is impossible by the issue rule.
- DRAIN: wait for inflight==0 and buffer empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then go to IDLE. Status values hold until the next accept.
- Latency: in_char accepted at cycle t appears on out_char at t+2 when the buffer was empty.

Optional Feature:
CAESAR_CTRL_ABORT_EN: adds input `abort` (1 bit) and output `sts_aborted` (1 bit, reset 0, cleared on accept).
- With the macro: abort high in RUN or DRAIN flushes the buffer, drops the in-flight char, sets sts_aborted=1, goes to DONE, and consumes no more input. abort is ignored in IDLE and DONE.
- Without the macro: neither port exists, and messages always run to completion.

Test Plan:
- Encrypt, dir 0, key1=3, key2=5, len 2, "Hi" -> out "Pq" (0x50, 0x71); out_last on 'q'; done pulse; sts_char_cnt=2, sts_bad_cnt=0.
- Decrypt, dir 0, keys 3/5, "B" -> 'T' (0x54, wrap); encrypt, dir 1, keys 3/5, "c" -> 'u' (0x75).
- Encrypt, dir 0, keys 1/2, "a z" -> 'd',' ','c'; sts_bad_cnt=1; the space (0x20) is passed through unchanged.
- Command with key1=key2=4 -> sts_err_key=1, in_ready never high, done one cycle after the DONE entry; then a valid command is accepted.
- OBUF_DEPTH=3, out_ready=0, len 5 -> exactly 3 chars accepted, then in_ready=0; release out_ready -> remaining 2 accepted, 5 outputs in order.
- rst_n low for one cycle mid-RUN -> next cycle IDLE, out_valid=0, cmd_ready=1, counters 0.
